prbs_tx_sequencer: RTL and testbench

//  Sequences the PRBS31 bit generator into framed bursts for the SERDES TX path.
//  - Drives the generator enable.
//  - Captures its 1-cycle-latency output into a 2-entry buffer.
//  - Forwards bits to TX under valid/ready backpressure.
//  - Inserts idle gaps between bursts.
//  - Stops after N bursts, or runs continuously.

---
 rtl/prbs_seq_pkg.sv | 29 ++
 rtl/prbs_seq_checker.sv | 12 +
 rtl/seq_fifo2.sv | 79 +++++++
 rtl/prbs_tx_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_prbs_tx_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_seq_pkg.sv
// Shared types and default widths for the PRBS TX sequencer.
package prbs_seq_pkg;

  localparam int unsigned BURST_W_DEF = 16;
  localparam int unsigned GAP_W_DEF   = 8;
  localparam int unsigned NB_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // Number of entries held in the 2-deep bit buffer, from its flags.
  function automatic logic [1:0] fifo_occupancy(input logic empty, input logic full);
    logic [1:0] occ;
    if (full) begin
      occ = 2'd2;
    end else if (empty) begin
      occ = 2'd0;
    end else begin
      occ = 2'd1;
    end
    return occ;
  endfunction

endpackage

// File: rtl/prbs_seq_checker.sv
// Run-time checks on the sequencer's buffer handshake.
module prbs_seq_checker (
  input logic clk,
  input logic rstn,
  input logic prbs_valid,
  input logic fifo_full
);

  // A generator bit must never arrive while both buffer slots are occupied.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(prbs_valid && fifo_full));

endmodule

// File: rtl/seq_fifo2.sv
// Two-entry, one-bit FIFO with synchronous flush. Entry "head" is always the
// oldest bit; push and pop may coincide at any occupancy.
module seq_fifo2 (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic empty,
  output logic full
);

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       pop_ok_s;
  logic       push_ok_s;

  // Next-state of the two storage slots and the fill count.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pop_ok_s  = pop & (count_q != 2'd0);
    push_ok_s = push & ((count_q != 2'd2) | pop_ok_s);
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din;
          end else begin
            head_d = din;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = din;
          end else begin
            tail_d = din;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          tail_d  = 1'b0;
          count_d = count_q - 2'd1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign dout  = head_q & ~empty;

endmodule

// File: rtl/prbs_tx_sequencer.sv
// Frames the PRBS31 generator output into bursts separated by idle gaps and
// forwards the bits to the SERDES TX path under valid/ready backpressure.
module prbs_tx_sequencer
  import prbs_seq_pkg::*;
#(
  parameter int unsigned BURST_W = BURST_W_DEF,
  parameter int unsigned GAP_W   = GAP_W_DEF,
  parameter int unsigned NB_W    = NB_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [GAP_W-1:0]   cfg_gap_len,
  input  logic [NB_W-1:0]    cfg_num_bursts,
  output logic               prbs_en,
  input  logic               prbs_data,
  input  logic               prbs_valid,
  output logic               tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [NB_W-1:0]    burst_idx,
  output logic [CNT_W-1:0]   bits_sent
);

  seq_state_e         state_q, state_d;
  logic [BURST_W-1:0] burst_len_q, burst_len_d;
  logic [BURST_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [GAP_W-1:0]   gap_len_q, gap_len_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NB_W-1:0]    num_bursts_q, num_bursts_d;
  logic [NB_W-1:0]    burst_idx_q, burst_idx_d;
  logic [CNT_W-1:0]   bits_sent_q, bits_sent_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic       fifo_dout_s;
  logic       fifo_empty_s;
  logic       fifo_full_s;
  logic [1:0] occ_s;
  logic [2:0] credit_s;
  logic [2:0] occ_next_s;
  logic       pop_s;
  logic       push_s;
  logic       flush_s;
  logic       issues_left_s;
  logic       last_issue_s;
  logic       last_burst_s;
  logic       gap_done_s;
  logic       prbs_en_s;

  // Buffer handshakes and the issue credit. Occupancy is taken after this
  // cycle's pop so a full-rate stream keeps the generator enabled every cycle.
  always_comb begin
    occ_s         = fifo_occupancy(fifo_empty_s, fifo_full_s);
    pop_s         = ~fifo_empty_s & tx_ready;
    push_s        = prbs_valid & (state_q != ST_IDLE);
    flush_s       = abort & (state_q != ST_IDLE);
    issues_left_s = (issue_cnt_q < burst_len_q);
    credit_s      = {1'b0, occ_s} - {2'b00, pop_s} + {2'b00, inflight_q};
    occ_next_s    = {1'b0, occ_s} - {2'b00, pop_s} + {2'b00, push_s};
    last_issue_s  = ((issue_cnt_q + BURST_W'(1)) == burst_len_q);
    last_burst_s  = (num_bursts_q != '0) && (burst_idx_q == (num_bursts_q - NB_W'(1)));
    gap_done_s    = (gap_cnt_q == (gap_len_q - GAP_W'(1)));
    if ((state_q == ST_RUN) && issues_left_s && (credit_s < 3'd2)) begin
      prbs_en_s = 1'b1;
    end else begin
      prbs_en_s = 1'b0;
    end
  end

  // Sequencer next-state: burst/gap scheduling, counters and status pulses.
  always_comb begin
    state_d      = state_q;
    burst_len_d  = burst_len_q;
    issue_cnt_d  = issue_cnt_q;
    gap_len_d    = gap_len_q;
    gap_cnt_d    = gap_cnt_q;
    num_bursts_d = num_bursts_q;
    burst_idx_d  = burst_idx_q;
    inflight_d   = prbs_en_s;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    if (pop_s && (bits_sent_q != '1)) begin
      bits_sent_d = bits_sent_q + CNT_W'(1);
    end else begin
      bits_sent_d = bits_sent_q;
    end

    if (flush_s) begin
      // Abort wins over everything; the bit still in the generator is dropped.
      state_d    = ST_IDLE;
      aborted_d  = 1'b1;
      inflight_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            burst_len_d  = cfg_burst_len;
            gap_len_d    = cfg_gap_len;
            num_bursts_d = cfg_num_bursts;
            issue_cnt_d  = '0;
            gap_cnt_d    = '0;
            burst_idx_d  = '0;
            bits_sent_d  = '0;
            if (cfg_burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (prbs_en_s) begin
            issue_cnt_d = issue_cnt_q + BURST_W'(1);
            if (last_issue_s) begin
              if (last_burst_s) begin
                state_d = ST_DRAIN;
              end else if (gap_len_q == '0) begin
                issue_cnt_d = '0;
                burst_idx_d = burst_idx_q + NB_W'(1);
              end else begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
              end
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_GAP: begin
          if (gap_done_s) begin
            state_d     = ST_RUN;
            issue_cnt_d = '0;
            burst_idx_d = burst_idx_q + NB_W'(1);
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (occ_next_s == 3'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      burst_len_q  <= '0;
      issue_cnt_q  <= '0;
      gap_len_q    <= '0;
      gap_cnt_q    <= '0;
      num_bursts_q <= '0;
      burst_idx_q  <= '0;
      bits_sent_q  <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      issue_cnt_q  <= issue_cnt_d;
      gap_len_q    <= gap_len_d;
      gap_cnt_q    <= gap_cnt_d;
      num_bursts_q <= num_bursts_d;
      burst_idx_q  <= burst_idx_d;
      bits_sent_q  <= bits_sent_d;
      inflight_q   <= inflight_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  seq_fifo2 u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush_s),
    .push  (push_s),
    .din   (prbs_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  prbs_seq_checker u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .prbs_valid (prbs_valid),
    .fifo_full  (fifo_full_s)
  );

  assign prbs_en   = prbs_en_s;
  assign tx_data   = fifo_dout_s;
  assign tx_valid  = ~fifo_empty_s;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign burst_idx = burst_idx_q;
  assign bits_sent = bits_sent_q;

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Randomized self-checking bench for prbs_tx_sequencer with a PRBS31 source
// model and a reference bit sequence computed from the polynomial recursion.
module tb_prbs_tx_sequencer;

  localparam logic [30:0] SEED = 31'h2AB4_C3D1;
  localparam int REF_N = 8192;

  logic        clk = 1'b0;
  logic        rstn, start, abort, tx_ready;
  logic [15:0] cfg_burst_len;
  logic [7:0]  cfg_gap_len, cfg_num_bursts;
  logic        prbs_en, prbs_data, prbs_valid;
  logic        tx_data, tx_valid, busy, done, aborted;
  logic [7:0]  burst_idx;
  logic [31:0] bits_sent;
  logic [30:0] lfsr;

  prbs_tx_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_burst_len(cfg_burst_len), .cfg_gap_len(cfg_gap_len), .cfg_num_bursts(cfg_num_bursts),
    .prbs_en(prbs_en), .prbs_data(prbs_data), .prbs_valid(prbs_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .aborted(aborted),
    .burst_idx(burst_idx), .bits_sent(bits_sent)
  );

  always #5 clk = ~clk;

  // PRBS31 generator model (x^31 + x^28 + 1), one cycle of latency, shares rstn.
  always @(posedge clk) begin
    if (!rstn) begin
      lfsr       <= SEED;
      prbs_valid <= 1'b0;
      prbs_data  <= 1'b0;
    end else begin
      prbs_valid <= prbs_en;
      if (prbs_en) begin
        lfsr      <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
        prbs_data <= lfsr[30] ^ lfsr[27];
      end
    end
  end

  bit ref_arr [0:REF_N+30];
  bit ref_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, gen_idx = 0, mode = 0;
  int en_cnt, hs_cnt, done_cnt, aborted_cnt, idle_cnt;
  int first_valid, last_hs, done_cyc, job_cyc;
  int cur_b = 0, period = 1, prof_len = 0;
  bit prof_on = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: observe at negedge, advance past posedge, drive tx_ready.
  task automatic step();
    int rel;
    @(negedge clk);
    if (prbs_en === 1'b1) begin
      if (gen_idx < REF_N) ref_q.push_back(ref_arr[gen_idx + 31]);
      if (cur_b != 0) chk("burst_idx", burst_idx, (en_cnt / cur_b) % 256);
      en_cnt++;
      gen_idx++;
    end
    if (prof_on && cyc > job_cyc) begin
      rel = cyc - job_cyc - 1;
      if (rel < prof_len + 4)
        chk("en_profile", prbs_en, ((rel < prof_len) && ((rel % period) < cur_b)) ? 1 : 0);
    end
    if (tx_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (ref_q.size() == 0) chk("tx_extra_bit", 1, 0);
      else chk("tx_bit", tx_data, ref_q.pop_front());
      hs_cnt++;
      last_hs = cyc;
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (aborted === 1'b1) aborted_cnt++;
    if (busy !== 1'b1) idle_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      2:       tx_ready = ($urandom_range(0, 2) == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_job(input int b, input int g, input int n, input bit prof);
    cfg_burst_len = 16'(b); cfg_gap_len = 8'(g); cfg_num_bursts = 8'(n);
    en_cnt = 0; hs_cnt = 0; done_cnt = 0; aborted_cnt = 0;
    first_valid = -1; last_hs = -1; done_cyc = -1;
    cur_b = b; period = b + g; job_cyc = cyc; prof_on = prof;
    prof_len = (n == 0) ? (1 << 30) : n * (b + g) - g;
    start = 1'b1;
    step();
    start = 1'b0;
    idle_cnt = 0;
    cfg_burst_len = 16'($urandom); cfg_gap_len = 8'($urandom); cfg_num_bursts = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin step(); k++; end
    chk("done_seen", done_cnt, 1);
  endtask

  task automatic finish_job(input int exp_bits);
    chk("bits_handshaken", hs_cnt, exp_bits);
    chk("bits_sent", bits_sent, exp_bits);
    chk("done_after_last_hs", done_cyc - last_hs, 1);
    chk("busy_after_done", busy, 0);
    chk("ref_queue_left", ref_q.size(), 0);
    step();
    chk("done_single_pulse", done_cnt, 1);
    prof_on = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prbs_en"}, prbs_en, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_burst_idx"}, burst_idx, 0);
    chk({tag, "_bits_sent"}, bits_sent, 0);
  endtask

  initial begin
    for (int i = 0; i < 31; i++) ref_arr[i] = SEED[30 - i];
    for (int i = 31; i < REF_N + 31; i++) ref_arr[i] = ref_arr[i - 31] ^ ref_arr[i - 28];

    rstn = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    cfg_burst_len = '0; cfg_gap_len = '0; cfg_num_bursts = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rstn = 1'b1;
    ref_q.delete(); gen_idx = 0;
    step();

    // Single 8-bit burst at full rate.
    mode = 1;
    start_job(8, 0, 1, 1);
    wait_done(100);
    chk("first_valid_latency", first_valid - (job_cyc + 1), 2);
    finish_job(8);

    // Three 4-bit bursts separated by 3 idle cycles.
    start_job(4, 3, 3, 1);
    wait_done(200);
    chk("last_burst_idx", burst_idx, 2);
    finish_job(12);

    // Zero-length burst: immediate done, nothing issued.
    start_job(0, 2, 1, 0);
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 0);
    chk("zero_len_bits_sent", bits_sent, 0);
    step();
    chk("zero_len_no_issue", en_cnt, 0);

    // 16-bit burst with sparse tx_ready and a start pulse that must be ignored.
    mode = 2;
    start_job(16, 0, 1, 0);
    repeat (5) step();
    cfg_burst_len = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(2000);
    finish_job(16);

    // TX stalled for 10 cycles after start.
    mode = 0;
    start_job(6, 0, 1, 0);
    repeat (10) step();
    chk("stall_issues", en_cnt, 2);
    chk("stall_tx_valid", tx_valid, 1);
    mode = 1; tx_ready = 1'b1;
    wait_done(200);
    finish_job(6);

    // Abort with both buffer entries occupied.
    mode = 0; tx_ready = 1'b0;
    start_job(8, 0, 1, 0);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    ref_q.delete();
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_prbs_en", prbs_en, 0);
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    repeat (5) step();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_pulse_count", aborted_cnt, 1);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ignored", aborted, 0);

    // Abort with a bit in flight, then restart at once: the dropped bit must not appear.
    mode = 1; tx_ready = 1'b1;
    start_job(8, 0, 1, 0);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    ref_q.delete();
    start_job(4, 0, 1, 1);
    wait_done(100);
    finish_job(4);

    // Random configurations under random backpressure.
    mode = 3;
    for (int it = 0; it < 4; it++) begin
      int b = $urandom_range(1, 10);
      int g = $urandom_range(0, 3);
      int n = $urandom_range(1, 3);
      start_job(b, g, n, 0);
      wait_done(3000);
      finish_job(b * n);
    end

    // Continuous mode: burst_idx wraps; then reset mid-run.
    mode = 1; tx_ready = 1'b1;
    start_job(2, 1, 0, 1);
    repeat (800) step();
    chk("cont_busy_low_cycles", idle_cnt, 0);
    chk("cont_no_done", done_cnt, 0);
    chk("cont_wrapped", (en_cnt / 2) > 256, 1);
    rstn = 1'b0;
    step();
    prof_on = 0; cur_b = 0;
    chk_all_zero("midrun_reset");
    rstn = 1'b1;
    ref_q.delete(); gen_idx = 0;
    step();

    // Generator restarts from its seed after reset.
    start_job(5, 0, 1, 1);
    wait_done(100);
    finish_job(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
